// File: rtl/ahb_default_slave.sv
// Default AHB slave: answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR
// response and keeps a debug log of the first fault plus a saturating error count.
module ahb_default_slave #(
   parameter int unsigned AHB_ADDR_WIDTH = 32,
   parameter int unsigned ERR_CNT_WIDTH  = 8
) (
   input  logic                      hclk,
   input  logic                      hreset_n,
   input  logic                      hsel,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]                htrans,
   input  logic                      hwrite,
   input  logic                      hready,
   output logic                      hreadyout,
   output logic [1:0]                hresp,
   input  logic                      err_clear,
   output logic                      err_valid,
   output logic [AHB_ADDR_WIDTH-1:0] err_addr,
   output logic                      err_write,
   output logic                      err_overflow,
   output logic [ERR_CNT_WIDTH-1:0]  err_count,
   output logic                      err_irq
);

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ERR1 = 2'b01,
      ST_ERR2 = 2'b10
   } state_e;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   state_e state, state_nxt;
   logic   err_xfer;
   logic   err_enter;

   // ERR1 drives hreadyout low, so nothing is sampled there
   assign err_xfer  = hsel && hready &&
                      ((htrans == HT_NONSEQ) || (htrans == HT_SEQ));
   assign err_enter = (state != ST_ERR1) && err_xfer;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: state_nxt = err_xfer ? ST_ERR1 : ST_IDLE;
         ST_ERR1: state_nxt = ST_ERR2;
         ST_ERR2: state_nxt = err_xfer ? ST_ERR1 : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      hreadyout = 1'b1;
      hresp     = RESP_OKAY;
      err_irq   = 1'b0;
      unique case (state)
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = RESP_ERROR;
            err_irq   = 1'b1;
         end
         ST_ERR2: hresp = RESP_ERROR;
         default: ;
      endcase
   end

   // A clear on the same edge as a new error acts first, so that error becomes the first logged
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         err_valid    <= 1'b0;
         err_addr     <= '0;
         err_write    <= 1'b0;
         err_overflow <= 1'b0;
         err_count    <= '0;
      end else if (err_enter) begin
         if (err_clear) begin
            err_count <= ERR_CNT_WIDTH'(1);
         end else if (err_count != '1) begin
            err_count <= err_count + 1'b1;
         end
         if (err_clear || !err_valid) begin
            err_valid    <= 1'b1;
            err_addr     <= haddr;
            err_write    <= hwrite;
            err_overflow <= 1'b0;
         end else begin
            err_overflow <= 1'b1;
         end
      end else if (err_clear) begin
         err_valid    <= 1'b0;
         err_overflow <= 1'b0;
         err_count    <= '0;
      end
   end

endmodule
